// File: rtl/point_update_sequencer.sv
// point_update_sequencer: walks every active point of the soft body through
// the shared update_point datapath one at a time, writing each result back
// into the point register file. A per-point watchdog bounds the wait for a
// result so a stuck collision search cannot stall the whole frame.
module point_update_sequencer #(
    parameter int NUM_POINTS        = 8,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 3,
    parameter int TIMEOUT_CYCLES    = 256,
    parameter int IDX_W             = $clog2(NUM_POINTS + 1)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         frame_start_in,
    input  logic [IDX_W-1:0]             num_points_in,
    output logic [IDX_W-1:0]             rd_idx_out,
    input  logic [POSITION_SIZE-1:0]     pos_x_in,
    input  logic [POSITION_SIZE-1:0]     pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]     vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]     vel_y_in,
    input  logic [ACCELERATION_SIZE-1:0] acc_x_in,
    input  logic [ACCELERATION_SIZE-1:0] acc_y_in,
    output logic                         upd_begin_out,
    output logic [POSITION_SIZE-1:0]     upd_pos_x_out,
    output logic [POSITION_SIZE-1:0]     upd_pos_y_out,
    output logic [VELOCITY_SIZE-1:0]     upd_vel_x_out,
    output logic [VELOCITY_SIZE-1:0]     upd_vel_y_out,
    output logic [ACCELERATION_SIZE-1:0] upd_acc_x_out,
    output logic [ACCELERATION_SIZE-1:0] upd_acc_y_out,
    input  logic                         upd_result_in,
    input  logic [POSITION_SIZE-1:0]     upd_new_pos_x_in,
    input  logic [POSITION_SIZE-1:0]     upd_new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]     upd_new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]     upd_new_vel_y_in,
    output logic                         wr_en_out,
    output logic [IDX_W-1:0]             wr_idx_out,
    output logic [POSITION_SIZE-1:0]     wr_pos_x_out,
    output logic [POSITION_SIZE-1:0]     wr_pos_y_out,
    output logic [VELOCITY_SIZE-1:0]     wr_vel_x_out,
    output logic [VELOCITY_SIZE-1:0]     wr_vel_y_out,
    output logic                         busy_out,
    output logic                         frame_done_out,
    output logic                         timeout_err_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  count_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [IDX_W-1:0]  count_next;

    // Requested count clamped to the register-file capacity.
    assign count_next = (num_points_in > IDX_W'(NUM_POINTS)) ? IDX_W'(NUM_POINTS)
                                                             : num_points_in;

    // The same index addresses the read port and the write-back port; both
    // only matter in FETCH and WRITE respectively.
    assign rd_idx_out = idx_reg;
    assign wr_idx_out = idx_reg;

    // Frame FSM; the strobes are registered so each is set on entry to the
    // state it belongs to and cleared by default on every other cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            count_reg       <= '0;
            wait_cnt_reg    <= '0;
            upd_begin_out   <= 1'b0;
            upd_pos_x_out   <= '0;
            upd_pos_y_out   <= '0;
            upd_vel_x_out   <= '0;
            upd_vel_y_out   <= '0;
            upd_acc_x_out   <= '0;
            upd_acc_y_out   <= '0;
            wr_en_out       <= 1'b0;
            wr_pos_x_out    <= '0;
            wr_pos_y_out    <= '0;
            wr_vel_x_out    <= '0;
            wr_vel_y_out    <= '0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            upd_begin_out  <= 1'b0;
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (frame_start_in) begin
                        count_reg       <= count_next;
                        idx_reg         <= '0;
                        timeout_err_out <= 1'b0;
                        busy_out        <= 1'b1;
                        if (count_next == '0) begin
                            state_reg      <= S_DONE;
                            frame_done_out <= 1'b1;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    upd_pos_x_out <= pos_x_in;
                    upd_pos_y_out <= pos_y_in;
                    upd_vel_x_out <= vel_x_in;
                    upd_vel_y_out <= vel_y_in;
                    upd_acc_x_out <= acc_x_in;
                    upd_acc_y_out <= acc_y_in;
                    upd_begin_out <= 1'b1;
                    state_reg     <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    // A result in the final watchdog cycle still counts.
                    if (upd_result_in) begin
                        wr_pos_x_out <= upd_new_pos_x_in;
                        wr_pos_y_out <= upd_new_pos_y_in;
                        wr_vel_x_out <= upd_new_vel_x_in;
                        wr_vel_y_out <= upd_new_vel_y_in;
                        wr_en_out    <= 1'b1;
                        state_reg    <= S_WRITE;
                    end else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_out <= 1'b1;
                        state_reg       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (idx_reg == count_reg - IDX_W'(1)) begin
                        state_reg      <= S_DONE;
                        frame_done_out <= 1'b1;
                    end else begin
                        idx_reg   <= idx_reg + IDX_W'(1);
                        state_reg <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy_out  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_out  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_point_update_sequencer.sv
// Bench for point_update_sequencer: a point register file and an update_point
// model surround the DUT; every cycle of a frame is compared against the
// schedule derived from per-point costs (FETCH + LAUNCH + wait + WRITE).
module tb_point_update_sequencer;

    localparam int NP = 8;
    localparam int PS = 8;
    localparam int VS = 8;
    localparam int AS = 3;
    localparam int TO = 16;
    localparam int IW = $clog2(NP + 1);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          frame_start_in;
    logic [IW-1:0] num_points_in;
    logic [IW-1:0] rd_idx_out;
    logic [PS-1:0] pos_x_in, pos_y_in;
    logic [VS-1:0] vel_x_in, vel_y_in;
    logic [AS-1:0] acc_x_in, acc_y_in;
    logic          upd_begin_out;
    logic [PS-1:0] upd_pos_x_out, upd_pos_y_out;
    logic [VS-1:0] upd_vel_x_out, upd_vel_y_out;
    logic [AS-1:0] upd_acc_x_out, upd_acc_y_out;
    logic          upd_result_in;
    logic [PS-1:0] upd_new_pos_x_in, upd_new_pos_y_in;
    logic [VS-1:0] upd_new_vel_x_in, upd_new_vel_y_in;
    logic          wr_en_out;
    logic [IW-1:0] wr_idx_out;
    logic [PS-1:0] wr_pos_x_out, wr_pos_y_out;
    logic [VS-1:0] wr_vel_x_out, wr_vel_y_out;
    logic          busy_out;
    logic          frame_done_out;
    logic          timeout_err_out;

    always #5 clk_in = ~clk_in;

    point_update_sequencer #(
        .NUM_POINTS(NP), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS),
        .ACCELERATION_SIZE(AS), .TIMEOUT_CYCLES(TO), .IDX_W(IW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .num_points_in(num_points_in), .rd_idx_out(rd_idx_out),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .acc_x_in(acc_x_in), .acc_y_in(acc_y_in),
        .upd_begin_out(upd_begin_out),
        .upd_pos_x_out(upd_pos_x_out), .upd_pos_y_out(upd_pos_y_out),
        .upd_vel_x_out(upd_vel_x_out), .upd_vel_y_out(upd_vel_y_out),
        .upd_acc_x_out(upd_acc_x_out), .upd_acc_y_out(upd_acc_y_out),
        .upd_result_in(upd_result_in),
        .upd_new_pos_x_in(upd_new_pos_x_in), .upd_new_pos_y_in(upd_new_pos_y_in),
        .upd_new_vel_x_in(upd_new_vel_x_in), .upd_new_vel_y_in(upd_new_vel_y_in),
        .wr_en_out(wr_en_out), .wr_idx_out(wr_idx_out),
        .wr_pos_x_out(wr_pos_x_out), .wr_pos_y_out(wr_pos_y_out),
        .wr_vel_x_out(wr_vel_x_out), .wr_vel_y_out(wr_vel_y_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out),
        .timeout_err_out(timeout_err_out)
    );

    // Point register file with combinational read.
    logic [PS-1:0] rf_px [NP];
    logic [PS-1:0] rf_py [NP];
    logic [VS-1:0] rf_vx [NP];
    logic [VS-1:0] rf_vy [NP];
    logic [AS-1:0] rf_ax [NP];
    logic [AS-1:0] rf_ay [NP];

    always_comb begin
        pos_x_in = '0; pos_y_in = '0; vel_x_in = '0;
        vel_y_in = '0; acc_x_in = '0; acc_y_in = '0;
        if (int'(rd_idx_out) < NP) begin
            pos_x_in = rf_px[int'(rd_idx_out)];
            pos_y_in = rf_py[int'(rd_idx_out)];
            vel_x_in = rf_vx[int'(rd_idx_out)];
            vel_y_in = rf_vy[int'(rd_idx_out)];
            acc_x_in = rf_ax[int'(rd_idx_out)];
            acc_y_in = rf_ay[int'(rd_idx_out)];
        end
    end

    int checks = 0;
    int errors = 0;
    int cur_off = 0;
    int d_pt [NP];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s off=%0d actual=%0d required=%0d", name, cur_off, act, exp);
        end
    endtask

    // One frame: start pulse in offset 0, then compare every cycle against
    // the schedule built from the per-point costs. rst_off > 0 asserts reset
    // during that offset and then checks that the frame is abandoned.
    task automatic run_frame(input int num, input int hung_mask, input bit extras,
                             input bit spurious, input int rst_off,
                             output int done_seen, output int writes);
        logic [PS-1:0] s_px [NP];
        logic [PS-1:0] s_py [NP];
        logic [VS-1:0] s_vx [NP];
        logic [VS-1:0] s_vy [NP];
        logic [AS-1:0] s_ax [NP];
        logic [AS-1:0] s_ay [NP];
        logic [PS-1:0] op_px, op_py;
        logic [VS-1:0] op_vx, op_vy;
        bit  hung [NP];
        int  fetch_off [NP];
        int  wr_off [NP];
        int  n_eff, s, done_off, first_to, last, bcnt, resp_at;
        bit  eb, ew;
        int  bi, wi;
        n_eff = (num > NP) ? NP : num;
        first_to = -1;
        s = 1;
        for (int i = 0; i < NP; i++) begin
            s_px[i] = rf_px[i]; s_py[i] = rf_py[i]; s_vx[i] = rf_vx[i];
            s_vy[i] = rf_vy[i]; s_ax[i] = rf_ax[i]; s_ay[i] = rf_ay[i];
            hung[i] = hung_mask[i];
            fetch_off[i] = -10;
            wr_off[i] = -10;
        end
        for (int i = 0; i < n_eff; i++) begin
            fetch_off[i] = s;
            wr_off[i] = s + 2 + (hung[i] ? TO : d_pt[i]);
            if (hung[i] && first_to < 0) first_to = wr_off[i];
            s = wr_off[i] + 1;
        end
        done_off = (n_eff == 0) ? 1 : s;
        last = (rst_off > 0) ? rst_off + 20 : done_off + 2;
        done_seen = -1;
        writes = 0;
        bcnt = 0;
        resp_at = -1;
        op_px = '0; op_py = '0; op_vx = '0; op_vy = '0;
        @(negedge clk_in);
        num_points_in = IW'(num);
        for (int off = 0; off <= last; off++) begin
            if (off > 0) @(negedge clk_in);
            cur_off = off;
            if (off > 0) begin
                if (rst_off > 0 && off == rst_off + 1) begin
                    chk("rst_all_zero", int'(|{busy_out, rd_idx_out, upd_begin_out,
                        upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out,
                        upd_acc_x_out, upd_acc_y_out, wr_en_out, wr_idx_out,
                        wr_pos_x_out, wr_pos_y_out, wr_vel_x_out, wr_vel_y_out,
                        frame_done_out, timeout_err_out}), 0);
                    rst_in = 1'b0;
                end else if (rst_off > 0 && off > rst_off + 1) begin
                    chk("post_rst_busy", int'(busy_out), 0);
                    chk("post_rst_wr_en", int'(wr_en_out), 0);
                    chk("post_rst_done", int'(frame_done_out), 0);
                end else begin
                    eb = 1'b0; ew = 1'b0; bi = 0; wi = 0;
                    for (int i = 0; i < n_eff; i++) begin
                        if (off == fetch_off[i] + 1) begin eb = 1'b1; bi = i; end
                        if (off == wr_off[i]) begin ew = !hung[i]; wi = i; end
                    end
                    chk("begin", int'(upd_begin_out), int'(eb));
                    if (eb) begin
                        chk("upd_pos_x", int'(upd_pos_x_out), int'(s_px[bi]));
                        chk("upd_pos_y", int'(upd_pos_y_out), int'(s_py[bi]));
                        chk("upd_vel_x", int'(upd_vel_x_out), int'(s_vx[bi]));
                        chk("upd_vel_y", int'(upd_vel_y_out), int'(s_vy[bi]));
                        chk("upd_acc_x", int'(upd_acc_x_out), int'(s_ax[bi]));
                        chk("upd_acc_y", int'(upd_acc_y_out), int'(s_ay[bi]));
                    end
                    chk("wr_en", int'(wr_en_out), int'(ew));
                    if (ew) begin
                        chk("wr_idx", int'(wr_idx_out), wi);
                        chk("wr_pos_x", int'(wr_pos_x_out), int'(PS'(s_px[wi] + 1'b1)));
                        chk("wr_pos_y", int'(wr_pos_y_out), int'(PS'(s_py[wi] + 1'b1)));
                        chk("wr_vel_x", int'(wr_vel_x_out), int'(VS'(s_vx[wi] - 1'b1)));
                        chk("wr_vel_y", int'(wr_vel_y_out), int'(VS'(s_vy[wi] - 1'b1)));
                    end
                    chk("done", int'(frame_done_out), int'(off == done_off));
                    chk("busy", int'(busy_out), int'(off <= done_off));
                    chk("timeout_err", int'(timeout_err_out),
                        int'(first_to >= 0 && off >= first_to));
                end
            end
            // Observe the DUT as its environment would.
            if (wr_en_out) begin
                writes++;
                $display("write off=%0d idx=%0d pos=(%0d,%0d) vel=(%0d,%0d)", off,
                         wr_idx_out, $signed(wr_pos_x_out), $signed(wr_pos_y_out),
                         $signed(wr_vel_x_out), $signed(wr_vel_y_out));
                if (int'(wr_idx_out) < NP) begin
                    rf_px[int'(wr_idx_out)] = wr_pos_x_out;
                    rf_py[int'(wr_idx_out)] = wr_pos_y_out;
                    rf_vx[int'(wr_idx_out)] = wr_vel_x_out;
                    rf_vy[int'(wr_idx_out)] = wr_vel_y_out;
                end
            end
            if (frame_done_out && done_seen < 0) done_seen = off;
            if (upd_begin_out && bcnt < NP) begin
                op_px = upd_pos_x_out; op_py = upd_pos_y_out;
                op_vx = upd_vel_x_out; op_vy = upd_vel_y_out;
                resp_at = hung[bcnt] ? -1 : off + d_pt[bcnt];
                bcnt++;
            end
            // Drive inputs for this cycle.
            frame_start_in = (off == 0) ||
                             (extras && (off == 3 || off == 8) && off <= done_off);
            upd_result_in = 1'b0;
            upd_new_pos_x_in = '0; upd_new_pos_y_in = '0;
            upd_new_vel_x_in = '0; upd_new_vel_y_in = '0;
            if (off == resp_at) begin
                upd_result_in = 1'b1;
                upd_new_pos_x_in = op_px + 1'b1; upd_new_pos_y_in = op_py + 1'b1;
                upd_new_vel_x_in = op_vx - 1'b1; upd_new_vel_y_in = op_vy - 1'b1;
            end
            if (spurious) begin
                for (int i = 0; i < n_eff; i++) begin
                    if (off == fetch_off[i]) begin
                        upd_result_in = 1'b1;
                        upd_new_pos_x_in = 8'hA5; upd_new_pos_y_in = 8'h5A;
                        upd_new_vel_x_in = 8'hC3; upd_new_vel_y_in = 8'h3C;
                    end
                end
            end
            if (rst_off > 0 && off == rst_off) begin
                rst_in = 1'b1;
                resp_at = -1;
            end
        end
        frame_start_in = 1'b0;
        upd_result_in = 1'b0;
        if (rst_off == 0) begin
            for (int i = 0; i < NP; i++) begin
                if (i < n_eff && !hung[i])
                    chk("rf_final", int'({rf_px[i], rf_py[i], rf_vx[i], rf_vy[i]}),
                        int'({PS'(s_px[i] + 1'b1), PS'(s_py[i] + 1'b1),
                              VS'(s_vx[i] - 1'b1), VS'(s_vy[i] - 1'b1)}));
                else
                    chk("rf_final", int'({rf_px[i], rf_py[i], rf_vx[i], rf_vy[i]}),
                        int'({s_px[i], s_py[i], s_vx[i], s_vy[i]}));
            end
        end
    endtask

    typedef struct {
        int num;
        int d;
        int hung_mask;
        bit extras;
        bit spurious;
        int rst_off;
        int exp_done;
        int exp_writes;
    } vec_t;

    task automatic randomize_rf();
        for (int i = 0; i < NP; i++) begin
            rf_px[i] = PS'($urandom); rf_py[i] = PS'($urandom);
            rf_vx[i] = VS'($urandom); rf_vy[i] = VS'($urandom);
            rf_ax[i] = AS'($urandom); rf_ay[i] = AS'($urandom);
        end
    endtask

    initial begin
        vec_t tbl [8];
        int done_seen, writes, num, mask;
        tbl[0] = '{3, 2, 0,    1'b0, 1'b0, 0, 16, 3};
        tbl[1] = '{0, 2, 0,    1'b0, 1'b0, 0, 1,  0};
        tbl[2] = '{12, 2, 0,   1'b0, 1'b0, 0, 41, 8};
        tbl[3] = '{3, 2, 2,    1'b0, 1'b0, 0, 30, 2};
        tbl[4] = '{3, 2, 0,    1'b1, 1'b1, 0, 16, 3};
        tbl[5] = '{3, 2, 0,    1'b0, 1'b0, 8, -1, 1};
        tbl[6] = '{1, 1, 0,    1'b0, 1'b0, 0, 5,  1};
        tbl[7] = '{8, 1, 8'h80, 1'b0, 1'b0, 0, 48, 7};

        rst_in = 1'b1;
        frame_start_in = 1'b0;
        num_points_in = '0;
        upd_result_in = 1'b0;
        upd_new_pos_x_in = '0; upd_new_pos_y_in = '0;
        upd_new_vel_x_in = '0; upd_new_vel_y_in = '0;
        randomize_rf();
        repeat (3) @(negedge clk_in);
        chk("reset_all_zero", int'(|{busy_out, rd_idx_out, upd_begin_out,
            upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out,
            upd_acc_x_out, upd_acc_y_out, wr_en_out, wr_idx_out,
            wr_pos_x_out, wr_pos_y_out, wr_vel_x_out, wr_vel_y_out,
            frame_done_out, timeout_err_out}), 0);
        rst_in = 1'b0;

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NP; i++) d_pt[i] = tbl[t].d;
            randomize_rf();
            run_frame(tbl[t].num, tbl[t].hung_mask, tbl[t].extras, tbl[t].spurious,
                      tbl[t].rst_off, done_seen, writes);
            chk("tbl_done_off", done_seen, tbl[t].exp_done);
            chk("tbl_writes", writes, tbl[t].exp_writes);
            $display("frame vec=%0d num=%0d done_off=%0d writes=%0d timeout_err=%0d",
                     t, tbl[t].num, done_seen, writes, timeout_err_out);
        end

        for (int r = 0; r < 15; r++) begin
            num = int'($urandom_range(0, 12));
            mask = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : 0;
            for (int i = 0; i < NP; i++) d_pt[i] = int'($urandom_range(1, 6));
            randomize_rf();
            run_frame(num, mask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      0, done_seen, writes);
            $display("frame rand=%0d num=%0d hung=0x%02h done_off=%0d writes=%0d",
                     r, num, mask, done_seen, writes);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/point_update_sequencer.md
# point_update_sequencer

Frame-level controller that walks every point of the soft-body car through the single shared `update_point` datapath, one point at a time. On a frame-start pulse it reads each point's state from the point register file, launches `update_point`, waits for its result, and writes the new position and velocity back. It pulses `frame_done_out` when all active points are written. A watchdog prevents a hung collision search from stalling the frame.

## Interface
Parameters:
- `NUM_POINTS`, 8: capacity of the point register file.
- `POSITION_SIZE`, 8: signed position width.
- `VELOCITY_SIZE`, 8: signed velocity width.
- `ACCELERATION_SIZE`, 3: signed acceleration width.
- `TIMEOUT_CYCLES`, 256: maximum number of WAIT cycles per point.
- `IDX_W`, $clog2(NUM_POINTS+1): width of index and count fields.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous, active-high reset.
- `frame_start_in` in 1: one-cycle request to update all points.
- `num_points_in` in IDX_W: active point count, latched at start.
- `rd_idx_out` out IDX_W: register-file read index (combinational read).
- `pos_x_in`, `pos_y_in` in POSITION_SIZE: point position at `rd_idx_out`.
- `vel_x_in`, `vel_y_in` in VELOCITY_SIZE: point velocity at `rd_idx_out`.
- `acc_x_in`, `acc_y_in` in ACCELERATION_SIZE: point acceleration at `rd_idx_out`.
- `upd_begin_out` out 1: one-cycle begin pulse to `update_point`.
- `upd_pos_x_out`, `upd_pos_y_out`, `upd_vel_x_out`, `upd_vel_y_out`, `upd_acc_x_out`, `upd_acc_y_out` out (matching widths): registered operands for `update_point`.
- `upd_result_in` in 1: `update_point` done pulse.
- `upd_new_pos_x_in`, `upd_new_pos_y_in`, `upd_new_vel_x_in`, `upd_new_vel_y_in` in (matching widths): `update_point` results.
- `wr_en_out` out 1: write-back strobe.
- `wr_idx_out` out IDX_W: write-back index.
- `wr_pos_x_out`, `wr_pos_y_out`, `wr_vel_x_out`, `wr_vel_y_out` out (matching widths): write-back data.
- `busy_out` out 1: high in every state except IDLE.
- `frame_done_out` out 1: one-cycle completion pulse.
- `timeout_err_out` out 1: sticky flag, set when any point times out in the current frame.

## Operation
States: IDLE, FETCH, LAUNCH, WAIT, WRITE, DONE.
- **IDLE**
  - On `frame_start_in`: latch count = min(`num_points_in`, NUM_POINTS), set idx = 0, clear `timeout_err_out`.
  - Go to FETCH, or to DONE if count == 0.
- **FETCH**
  - `rd_idx_out` = idx.
  - Capture the `*_in` point fields into the `upd_*_out` registers.
  - Go to LAUNCH.
- **LAUNCH**
  - `upd_begin_out` = 1 for exactly this cycle.
  - Clear the wait counter.
  - Go to WAIT.
- **WAIT**
  - Increment the wait counter each cycle.
  - On `upd_result_in`: capture the `upd_new_*` values into the `wr_*` registers, set write-valid, go to WRITE.
  - Else, if counter == TIMEOUT_CYCLES-1: clear write-valid, set `timeout_err_out`, go to WRITE.
  - If result and timeout occur in the same cycle, the result wins.
- **WRITE**
  - `wr_en_out` = write-valid.
  - `wr_idx_out` = idx.
  - If idx == count-1, go to DONE. Otherwise increment idx and go to FETCH.
- **DONE**
  - `frame_done_out` = 1.
  - Go to IDLE.
- `frame_start_in` is ignored outside IDLE.
- `upd_result_in` is ignored outside WAIT.
- Write-back data passes through unmodified; there is no arithmetic other than the counters.
- Index and count never wrap, because idx ≤ NUM_POINTS-1.

## Timing
- Reset (synchronous, on the cycle `rst_in` is sampled high):
  - State goes to IDLE.
  - All outputs are 0, including idx, count, every `upd_*_out`, every `wr_*_out` and `timeout_err_out`.
  - Reset mid-frame abandons the frame: no `frame_done_out`, no further writes.
  - `update_point` shares `rst_in`.
- Frame timing, with `frame_start_in` in cycle T and `update_point` result arriving d ≥ 1 cycles after the begin pulse:
  - First FETCH at T+1.
  - Begin pulse at T+2.
  - Cost per point is d+3 cycles.
  - Last WRITE at T+N(d+3).
  - `frame_done_out` at T+N(d+3)+1.
  - `busy_out` is high from T+1 through the DONE cycle.
- Count == 0: `frame_done_out` at T+1 with no begin pulse and no writes.
- Timed-out point:
  - WAIT lasts TIMEOUT_CYCLES cycles.
  - The following WRITE cycle has `wr_en_out` = 0.
  - The stored point is left unchanged.
- `upd_*_out` hold steady from FETCH until the next FETCH.
- `wr_*` data and `wr_idx_out` are valid whenever `wr_en_out` is high.

## Test plan
- Reset, then `num_points_in` = 3, `update_point` model with d = 2 returning pos+1 and vel-1:
  - Writes to idx 0, 1, 2 at T+5, T+10, T+15.
  - `frame_done_out` at T+16.
  - Data correct for each point.
- `num_points_in` = 0:
  - `frame_done_out` at T+1.
  - No `upd_begin_out` and no `wr_en_out`.
- `num_points_in` = 12 with NUM_POINTS = 8:
  - Exactly 8 writes, idx 0 through 7.
  - `frame_done_out` once.
- Model never responds for point 1 (TIMEOUT_CYCLES = 16, d = 2 otherwise):
  - Point 1 WRITE has `wr_en_out` = 0.
  - `timeout_err_out` = 1 until the next `frame_start_in`.
  - Points 0 and 2 are written normally.
- Extra `frame_start_in` pulses while busy, plus a spurious `upd_result_in` in FETCH:
  - Both are ignored.
  - Frame timing is identical to the first scenario.
- `rst_in` asserted during WAIT of point 1:
  - Next cycle `busy_out` = 0 and all outputs = 0.
  - No write for point 1 and no `frame_done_out`.
  - A new frame after reset completes normally.
